// File: rtl/dmem_arbiter_pkg.sv
// Shared types and constants for the data-memory arbiter and the CPU it serves.
package dmem_arbiter_pkg;

  localparam int unsigned AW_DEF  = 8;
  localparam int unsigned DW_DEF  = 16;
  localparam int unsigned BURST_W = 4;

  typedef enum logic {
    OWN_CPU  = 1'b0,
    OWN_HOST = 1'b1
  } owner_t;

  // CPU opcodes that generate data-memory traffic
  localparam logic [3:0] OP_LW = 4'h4;
  localparam logic [3:0] OP_SW = 4'h5;

endpackage

// File: rtl/dmem_arbiter_if.sv
// CPU, host and memory-side signals of the data-memory arbiter.
// ARB_STATS_EN adds the conflict/wait statistics outputs.
interface dmem_arbiter_if
  import dmem_arbiter_pkg::*;
#(
  parameter int unsigned AW = AW_DEF,
  parameter int unsigned DW = DW_DEF
);
  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_gnt;
  logic          cpu_stall;
  logic          cpu_rvalid;
  logic [DW-1:0] cpu_rdata;

  logic          host_req;
  logic          host_we;
  logic [AW-1:0] host_addr;
  logic [DW-1:0] host_wdata;
  logic          host_lock;
  logic          host_gnt;
  logic          host_rvalid;
  logic [DW-1:0] host_rdata;

  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

`ifdef ARB_STATS_EN
  logic [15:0]   conflict_cnt;
  logic [15:0]   cpu_wait_cnt;
`endif

  // Arbiter side
  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_gnt, cpu_stall, cpu_rvalid, cpu_rdata,
    input  host_req, host_we, host_addr, host_wdata, host_lock,
    output host_gnt, host_rvalid, host_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
`ifdef ARB_STATS_EN
    , output conflict_cnt, cpu_wait_cnt
`endif
  );

  // Requesters and memory side
  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_gnt, cpu_stall, cpu_rvalid, cpu_rdata,
    output host_req, host_we, host_addr, host_wdata, host_lock,
    input  host_gnt, host_rvalid, host_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
`ifdef ARB_STATS_EN
    , input conflict_cnt, cpu_wait_cnt
`endif
  );

endinterface

// File: rtl/dmem_arbiter_grant.sv
// Two-way round-robin grant with host burst lock; purely combinational.
module rr_grant2
  import dmem_arbiter_pkg::*;
(
  input  logic   cpu_req_i,
  input  logic   host_req_i,
  input  owner_t last_owner_i,
  input  logic   lock_ok_i,
  output logic   cpu_gnt_o,
  output logic   host_gnt_o
);

  always_comb begin
    cpu_gnt_o  = 1'b0;
    host_gnt_o = 1'b0;
    if (cpu_req_i && host_req_i) begin
      if (lock_ok_i || (last_owner_i == OWN_CPU)) host_gnt_o = 1'b1;
      else                                        cpu_gnt_o  = 1'b1;
    end else begin
      cpu_gnt_o  = cpu_req_i;
      host_gnt_o = host_req_i;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port data memory between CPU load/store and the host port.
// ARB_STATS_EN adds saturating conflict and CPU-wait counters.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int unsigned AW        = AW_DEF,
  parameter int unsigned DW        = DW_DEF,
  parameter int unsigned MAX_BURST = 4
) (
  input logic           clk,
  input logic           rst,
  dmem_arbiter_if.slave bus
);

  logic               cpu_gnt_c;
  logic               host_gnt_c;
  logic               lock_ok_c;
  logic               mem_we_c;
  logic               cpu_rvalid_c;
  logic               host_rvalid_c;

  owner_t             last_owner_q, last_owner_d;
  logic               host_gnt_prev_q;
  logic [BURST_W-1:0] burst_cnt_q, burst_cnt_d;
  logic               rd_pending_q, rd_pending_d;
  owner_t             rd_owner_q, rd_owner_d;

  assign lock_ok_c = (last_owner_q == OWN_HOST) && host_gnt_prev_q && bus.host_lock &&
                     (burst_cnt_q < BURST_W'(MAX_BURST));

  // Requests are masked during reset so no grant escapes in that cycle
  rr_grant2 u_grant (
    .cpu_req_i    (bus.cpu_req & ~rst),
    .host_req_i   (bus.host_req & ~rst),
    .last_owner_i (last_owner_q),
    .lock_ok_i    (lock_ok_c),
    .cpu_gnt_o    (cpu_gnt_c),
    .host_gnt_o   (host_gnt_c)
  );

  assign bus.cpu_gnt   = cpu_gnt_c;
  assign bus.host_gnt  = host_gnt_c;
  assign bus.cpu_stall = bus.cpu_req & ~cpu_gnt_c;

  always_comb begin
    bus.mem_en    = 1'b0;
    mem_we_c      = 1'b0;
    bus.mem_addr  = AW'(0);
    bus.mem_wdata = DW'(0);
    if (cpu_gnt_c) begin
      bus.mem_en    = 1'b1;
      mem_we_c      = bus.cpu_we;
      bus.mem_addr  = bus.cpu_addr;
      bus.mem_wdata = bus.cpu_wdata;
    end else if (host_gnt_c) begin
      bus.mem_en    = 1'b1;
      mem_we_c      = bus.host_we;
      bus.mem_addr  = bus.host_addr;
      bus.mem_wdata = bus.host_wdata;
    end
  end
  assign bus.mem_we = mem_we_c;

  assign cpu_rvalid_c    = rd_pending_q && (rd_owner_q == OWN_CPU) && !rst;
  assign host_rvalid_c   = rd_pending_q && (rd_owner_q == OWN_HOST) && !rst;
  assign bus.cpu_rvalid  = cpu_rvalid_c;
  assign bus.host_rvalid = host_rvalid_c;
  assign bus.cpu_rdata   = cpu_rvalid_c  ? bus.mem_rdata : DW'(0);
  assign bus.host_rdata  = host_rvalid_c ? bus.mem_rdata : DW'(0);

  always_comb begin
    last_owner_d = last_owner_q;
    burst_cnt_d  = '0;
    rd_owner_d   = rd_owner_q;
    rd_pending_d = (cpu_gnt_c || host_gnt_c) && !mem_we_c;
    if (cpu_gnt_c) begin
      last_owner_d = OWN_CPU;
      rd_owner_d   = OWN_CPU;
    end else if (host_gnt_c) begin
      last_owner_d = OWN_HOST;
      rd_owner_d   = OWN_HOST;
    end
    // Burst count only survives an uninterrupted locked host run
    if (host_gnt_c && bus.host_lock) begin
      if (bus.cpu_req && (burst_cnt_q < BURST_W'(MAX_BURST))) burst_cnt_d = burst_cnt_q + BURST_W'(1);
      else                                                    burst_cnt_d = burst_cnt_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_owner_q    <= OWN_HOST;
      host_gnt_prev_q <= 1'b0;
      burst_cnt_q     <= '0;
      rd_pending_q    <= 1'b0;
      rd_owner_q      <= OWN_CPU;
    end else begin
      last_owner_q    <= last_owner_d;
      host_gnt_prev_q <= host_gnt_c;
      burst_cnt_q     <= burst_cnt_d;
      rd_pending_q    <= rd_pending_d;
      rd_owner_q      <= rd_owner_d;
    end
  end

`ifdef ARB_STATS_EN
  logic [15:0] conflict_cnt_q, conflict_cnt_d;
  logic [15:0] cpu_wait_cnt_q, cpu_wait_cnt_d;

  always_comb begin
    conflict_cnt_d = conflict_cnt_q;
    cpu_wait_cnt_d = cpu_wait_cnt_q;
    if (bus.cpu_req && bus.host_req && (conflict_cnt_q != 16'hFFFF))
      conflict_cnt_d = conflict_cnt_q + 16'd1;
    if (bus.cpu_stall && (cpu_wait_cnt_q != 16'hFFFF))
      cpu_wait_cnt_d = cpu_wait_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      conflict_cnt_q <= '0;
      cpu_wait_cnt_q <= '0;
    end else begin
      conflict_cnt_q <= conflict_cnt_d;
      cpu_wait_cnt_q <= cpu_wait_cnt_d;
    end
  end

  assign bus.conflict_cnt = conflict_cnt_q;
  assign bus.cpu_wait_cnt = cpu_wait_cnt_q;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: directed grant sequences, read-return checks.
module tb_dmem_arbiter;
  import dmem_arbiter_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dmem_arbiter_if #(.AW(8), .DW(16)) bus ();

  dmem_arbiter #(.AW(8), .DW(16), .MAX_BURST(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic        own;   // 0 = CPU, 1 = host
    logic [15:0] data;
  } rd_exp_t;
  rd_exp_t exp_q[$];

  // Memory model: unwritten words read back as 16'h1000 + address
  logic [255:0] wr_valid;
  logic [15:0]  wmem [256];
  always @(posedge clk) begin
    if (rst) wr_valid <= '0;
    else if (bus.mem_en && bus.mem_we) begin
      wr_valid[bus.mem_addr] <= 1'b1;
      wmem[bus.mem_addr]     <= bus.mem_wdata;
    end
    if (bus.mem_en && !bus.mem_we)
      bus.mem_rdata <= wr_valid[bus.mem_addr] ? wmem[bus.mem_addr] : 16'h1000 + 16'(bus.mem_addr);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: pops one expectation per rvalid
  always @(negedge clk) begin
    if (rst) begin
      chk("rst_cpu_rvalid", 32'(bus.cpu_rvalid), 32'd0);
      chk("rst_host_rvalid", 32'(bus.host_rvalid), 32'd0);
    end else if (bus.cpu_rvalid || bus.host_rvalid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_rvalid", 32'({bus.cpu_rvalid, bus.host_rvalid}), 32'd0);
      end else begin
        rd_exp_t e;
        e = exp_q.pop_front();
        chk("rvalid_owner", 32'(bus.host_rvalid), 32'(e.own));
        chk("rvalid_both", 32'(bus.cpu_rvalid & bus.host_rvalid), 32'd0);
        chk("rdata", 32'(e.own ? bus.host_rdata : bus.cpu_rdata), 32'(e.data));
        chk("other_rdata", 32'(e.own ? bus.cpu_rdata : bus.host_rdata), 32'd0);
      end
    end
  end

  task automatic set_cpu(input logic req, input logic we, input logic [7:0] a, input logic [15:0] d);
    bus.cpu_req = req; bus.cpu_we = we; bus.cpu_addr = a; bus.cpu_wdata = d;
  endtask

  task automatic set_host(input logic req, input logic we, input logic [7:0] a, input logic [15:0] d,
                          input logic lock);
    bus.host_req = req; bus.host_we = we; bus.host_addr = a; bus.host_wdata = d; bus.host_lock = lock;
  endtask

  // One cycle: check grants at mid-cycle, queue expected read data, advance
  task automatic step(input string name, input logic eg_c, input logic eg_h, input logic expect_rd,
                      input logic [15:0] exp_rd);
    logic [7:0] exp_addr;
    @(negedge clk);
    chk($sformatf("%s_cpu_gnt", name), 32'(bus.cpu_gnt), 32'(eg_c));
    chk($sformatf("%s_host_gnt", name), 32'(bus.host_gnt), 32'(eg_h));
    chk($sformatf("%s_stall", name), 32'(bus.cpu_stall), 32'(bus.cpu_req & ~eg_c));
    chk($sformatf("%s_mem_en", name), 32'(bus.mem_en), 32'(eg_c | eg_h));
    if (eg_c || eg_h) begin
      exp_addr = eg_c ? bus.cpu_addr : bus.host_addr;
      chk($sformatf("%s_mem_addr", name), 32'(bus.mem_addr), 32'(exp_addr));
    end
    if (expect_rd) exp_q.push_back(rd_exp_t'({eg_h, exp_rd}));
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    set_cpu(1'b1, 1'b0, 8'd0, 16'd0);
    set_host(1'b1, 1'b1, 8'd0, 16'd0, 1'b1);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("rst_gnt", 32'({bus.cpu_gnt, bus.host_gnt}), 32'd0);
      chk("rst_mem", 32'({bus.mem_en, bus.mem_we}), 32'd0);
      chk("rst_rdata", 32'({bus.cpu_rdata, bus.host_rdata}), 32'd0);
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    set_cpu(1'b0, 1'b0, 8'd0, 16'd0);
    set_host(1'b0, 1'b0, 8'd0, 16'd0, 1'b0);
  endtask

  initial begin
    set_cpu(1'b0, 1'b0, 8'd0, 16'd0);
    set_host(1'b0, 1'b0, 8'd0, 16'd0, 1'b0);
    do_reset(2);

    // Solo CPU store then load of the same word
    set_cpu(1'b1, 1'b1, 8'd3, 16'h00AA);
    step($sformatf("t1_op%0h", OP_SW), 1'b1, 1'b0, 1'b0, 16'h0);
    set_cpu(1'b1, 1'b0, 8'd3, 16'h0);
    step($sformatf("t1_op%0h", OP_LW), 1'b1, 1'b0, 1'b1, 16'h00AA);
    set_cpu(1'b0, 1'b0, 8'd0, 16'h0);
    step("t1_idle", 1'b0, 1'b0, 1'b0, 16'h0);

    // First conflict after reset goes to the CPU
    do_reset(1);
    set_cpu(1'b1, 1'b0, 8'd0, 16'h0);
    set_host(1'b1, 1'b0, 8'd0, 16'h0, 1'b0);
    step("t2_c0", 1'b1, 1'b0, 1'b1, 16'h1000);
    set_cpu(1'b0, 1'b0, 8'd0, 16'h0);
    step("t2_c1", 1'b0, 1'b1, 1'b1, 16'h1000);
    set_host(1'b0, 1'b0, 8'd0, 16'h0, 1'b0);
    step("t2_idle", 1'b0, 1'b0, 1'b0, 16'h0);

    // Sustained conflict without lock alternates C,H
    do_reset(1);
    set_cpu(1'b1, 1'b0, 8'd1, 16'h0);
    set_host(1'b1, 1'b0, 8'd2, 16'h0, 1'b0);
    for (int k = 0; k < 6; k++) begin
      logic ec;
      ec = ((k % 2) == 0);
      step($sformatf("t3_k%0d", k), ec, ~ec, 1'b1, ec ? 16'h1001 : 16'h1002);
    end
    set_cpu(1'b0, 1'b0, 8'd0, 16'h0);
    set_host(1'b0, 1'b0, 8'd0, 16'h0, 1'b0);
    step("t3_idle", 1'b0, 1'b0, 1'b0, 16'h0);
`ifdef ARB_STATS_EN
    chk("t6_conflict_cnt", 32'(bus.conflict_cnt), 32'd6);
    chk("t6_cpu_wait_cnt", 32'(bus.cpu_wait_cnt), 32'd3);
`endif

    // Host burst: two rounds of H,H,H,H,C; second round proves the count cleared
    set_cpu(1'b1, 1'b0, 8'd4, 16'h0);
    step("t4_solo", 1'b1, 1'b0, 1'b1, 16'h1004);
    set_cpu(1'b1, 1'b0, 8'd5, 16'h0);
    set_host(1'b1, 1'b0, 8'd6, 16'h0, 1'b1);
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < 5; k++) begin
        logic ec;
        ec = (k == 4);
        step($sformatf("t4_r%0d_k%0d", r, k), ec, ~ec, 1'b1, ec ? 16'h1005 : 16'h1006);
      end
    end
    set_cpu(1'b0, 1'b0, 8'd0, 16'h0);
    set_host(1'b0, 1'b0, 8'd0, 16'h0, 1'b0);
    step("t4_idle", 1'b0, 1'b0, 1'b0, 16'h0);

    // Reset right after a host read grant drops the pending rvalid
    set_host(1'b1, 1'b0, 8'd7, 16'h0, 1'b0);
    step("t5_hrd", 1'b0, 1'b1, 1'b0, 16'h0);
    do_reset(2);
    set_cpu(1'b1, 1'b0, 8'd8, 16'h0);
    set_host(1'b1, 1'b0, 8'd9, 16'h0, 1'b0);
    step("t5_c0", 1'b1, 1'b0, 1'b1, 16'h1008);
    set_cpu(1'b0, 1'b0, 8'd0, 16'h0);
    step("t5_c1", 1'b0, 1'b1, 1'b1, 16'h1009);
    set_host(1'b0, 1'b0, 8'd0, 16'h0, 1'b0);
    step("t5_idle0", 1'b0, 1'b0, 1'b0, 16'h0);
    step("t5_idle1", 1'b0, 1'b0, 1'b0, 16'h0);

    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
